// File: rtl/prog_interval_timer.sv
// Programmable interval timer: counts load_val prescaled ticks, then pulses time_out.
// Supports one-shot/periodic modes, pause, abort and restart with a live remaining count.
module prog_interval_timer #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TICK_US     = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             time_out,
    output logic [CNT_W-1:0] remaining
);

    localparam int PRESCALE = CLK_FREQ_HZ / 1000000 * TICK_US;
    localparam int PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic             load_ok;

    assign load_ok = start && (load_val != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            rem_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        to_d     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
            rem_d   = '0;
        end else if (load_ok) begin
            reload_d = load_val;
            rem_d    = load_val;
            mode_d   = mode;
            presc_d  = '0;
            state_d  = pause ? PAUSED : RUN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN, PAUSED: begin
                    // Leaving PAUSED counts on the same edge, so a pause costs exactly its length.
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        state_d = RUN;
                        if (presc_q == PRE_MAX) begin
                            presc_d = '0;
                            if (rem_q == CNT_W'(1)) begin
                                to_d = 1'b1;
                                if (mode_q) begin
                                    rem_d = reload_q;
                                end else begin
                                    rem_d   = '0;
                                    state_d = IDLE;
                                end
                            end else begin
                                rem_d = rem_q - CNT_W'(1);
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign busy      = busy_q;
    assign time_out  = to_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Bench for prog_interval_timer: directed scenarios plus random stimulus against
// an elapsed-cycle reference model (remaining = load - counted_cycles / PRESCALE).
module tb_prog_interval_timer;

    localparam int CNT_W = 8;
    localparam int P     = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic             busy;
    logic             time_out;
    logic [CNT_W-1:0] remaining;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    bit m_active;
    bit m_per;
    int m_load;
    int m_phase;
    bit m_to;

    prog_interval_timer #(
        .CLK_FREQ_HZ(1000000),
        .TICK_US    (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .load_val (load_val),
        .busy     (busy),
        .time_out (time_out),
        .remaining(remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_per    = 1'b0;
        m_load   = 0;
        m_phase  = 0;
        m_to     = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs applied to it.
    task automatic model_edge();
        bit to_n;
        to_n = 1'b0;
        if (stop) begin
            m_active = 1'b0;
        end else if (start && load_val != 0) begin
            m_active = 1'b1;
            m_per    = mode;
            m_load   = int'(load_val);
            m_phase  = 0;
        end else if (m_active && !pause) begin
            m_phase++;
            if (m_phase == m_load * P) begin
                to_n = 1'b1;
                if (m_per) m_phase = 0;
                else       m_active = 1'b0;
            end
        end
        m_to = to_n;
    endtask

    function automatic int model_rem();
        return m_active ? (m_load - m_phase / P) : 0;
    endfunction

    // Called at a negedge: apply inputs, take one posedge, compare at the next negedge.
    task automatic cyc(input bit st, input bit sp, input bit pa, input bit md, input int lv);
        start    = st;
        stop     = sp;
        pause    = pa;
        mode     = md;
        load_val = CNT_W'(lv);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_active));
        check("time_out", 32'(time_out), 32'(m_to));
        check("remaining", 32'(remaining), 32'(model_rem()));
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        mode     = 1'b0;
        load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_time_out", 32'(time_out), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // one-shot, load 3
        cyc(1, 0, 0, 0, 3);
        check("os_rem_e0", 32'(remaining), 32'd3);
        for (int e = 1; e <= 12; e++) begin
            cyc(0, 0, 0, 0, 0);
            if (e == 4)  check("os_rem_e4", 32'(remaining), 32'd2);
            if (e == 8)  check("os_rem_e8", 32'(remaining), 32'd1);
            if (e == 11) check("os_to_e11", 32'(time_out), 32'd0);
            if (e == 12) begin
                check("os_to_e12", 32'(time_out), 32'd1);
                check("os_busy_e12", 32'(busy), 32'd0);
                check("os_rem_e12", 32'(remaining), 32'd0);
            end
        end
        cyc(0, 0, 0, 0, 0);
        check("os_to_once", 32'(time_out), 32'd0);

        // periodic, load 2
        cyc(1, 0, 0, 1, 2);
        for (int e = 1; e <= 25; e++) begin
            cyc(0, 0, 0, 0, 0);
            check("per_to", 32'(time_out), 32'((e % 8) == 0));
            check("per_busy", 32'(busy), 32'd1);
            if (e % 8 == 0) check("per_reload", 32'(remaining), 32'd2);
        end
        cyc(0, 1, 0, 0, 0);

        // pause for 5 cycles from edge 3
        cyc(1, 0, 0, 0, 2);
        for (int e = 1; e <= 14; e++) begin
            cyc(0, 0, (e >= 3 && e <= 7), 0, 0);
            check("pause_to", 32'(time_out), 32'(e == 13));
            if (e >= 3 && e <= 7) check("pause_frozen", 32'(remaining), 32'd2);
        end

        // stop beats start on the expiry edge
        cyc(1, 0, 0, 1, 1);
        for (int e = 1; e <= 3; e++) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        check("stop_to", 32'(time_out), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_rem", 32'(remaining), 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("stop_to_after", 32'(time_out), 32'd0);
        cyc(1, 0, 0, 0, 0);
        check("zero_load_busy", 32'(busy), 32'd0);

        // restart mid-interval
        cyc(1, 0, 0, 0, 5);
        for (int e = 1; e <= 19; e++) begin
            if (e == 10) cyc(1, 0, 0, 0, 2);
            else         cyc(0, 0, 0, 0, 0);
            check("restart_to", 32'(time_out), 32'(e == 18));
        end

        // async reset between edges while running
        cyc(1, 0, 0, 1, 5);
        for (int e = 1; e <= 6; e++) cyc(0, 0, 0, 0, 0);
        check("pre_arst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_time_out", 32'(time_out), 32'd0);
        check("arst_remaining", 32'(remaining), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            bit st, sp, pa, md;
            int lv;
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 79) == 0);
            pa = ($urandom_range(0, 6) == 0);
            md = $urandom_range(0, 1) == 1;
            lv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            if ($urandom_range(0, 199) == 0) lv = 255;
            cyc(st, sp, pa, md, lv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
